// File: rtl/bcd_pkg.sv
// Shared constants and types for the binary-to-BCD converter.
package bcd_pkg;
  localparam int BCD_W    = 4;
  localparam int N_DIGITS = 4;
  localparam int BCD_MAX  = 9999;

  typedef enum logic {IDLE, CONV} state_t;
  typedef logic [BCD_W-1:0] bcd_t;
endpackage

// File: rtl/bcd_add3.sv
// Single-digit correction for shift-and-add-3: digits >= 5 get +3 before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  bcd_t d_t;

  assign d_t = d;
  assign q   = (d_t >= bcd_t'(5)) ? d_t + bcd_t'(3) : d_t;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock; digits update only on completion.
//   state | meaning
//   IDLE  | waiting for start; output digits hold the last result
//   CONV  | shifting one operand bit per cycle into the BCD scratch
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       one,
  output logic [3:0]       ten,
  output logic [3:0]       hunnid,
  output logic [3:0]       thousand
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam int SCR_W = BCD_W * N_DIGITS;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   operand;
  logic [SCR_W-1:0]   scratch, scratch_adj;
  logic [SCR_W+WIDTH-1:0] shifted;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;
  logic               over;
  logic               last;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .d (scratch[i*BCD_W +: BCD_W]),
      .q (scratch_adj[i*BCD_W +: BCD_W])
    );
  end

  assign shifted = {scratch_adj, operand} << 1;
  assign over    = 32'(bin) > 32'(BCD_MAX);
  assign last    = (state == CONV) && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV);
  end

  // Scratch and counter run every cycle; visible digits move only on the last iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand  <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      one      <= '0;
      ten      <= '0;
      hunnid   <= '0;
      thousand <= '0;
    end else begin
      done <= last;
      if (state == IDLE) begin
        if (start) begin
          operand  <= over ? WIDTH'(BCD_MAX) : bin;
          ovf_pend <= over;
          scratch  <= '0;
          cnt      <= CNT_W'(WIDTH - 1);
        end
      end else begin
        scratch <= shifted[SCR_W+WIDTH-1:WIDTH];
        operand <= shifted[WIDTH-1:0];
        cnt     <= cnt - CNT_W'(1);
        if (last) begin
          one      <= shifted[WIDTH +: BCD_W];
          ten      <= shifted[WIDTH+BCD_W +: BCD_W];
          hunnid   <= shifted[WIDTH+2*BCD_W +: BCD_W];
          thousand <= shifted[WIDTH+3*BCD_W +: BCD_W];
          ovf      <= ovf_pend;
        end
      end
    end
  end
endmodule
